// File: rtl/byte_striping_lanes_if.sv
// Handshake and bus bundle between the byte source, the striper and the per-lane encoders.
// Master drives the byte and control side; slave is the striper itself.
interface byte_striping_lanes_if #(
   parameter int WIDTH = 8,
   parameter int LANES = 4
);
   localparam int CW = $clog2(LANES);
   localparam int AW = CW + 1;

   logic                   ENB;
   logic                   laneVLD;
   logic [WIDTH-1:0]       byteStripingIN;
   logic                   flush;
   logic [AW-1:0]          activeLanes;
   logic                   inRDY;
   logic [LANES*WIDTH-1:0] stripedLanes;
   logic [LANES-1:0]       laneMask;
   logic                   byteStripingVLD;
   logic                   outRDY;
   logic [CW-1:0]          counter;

   modport master (
      output ENB, laneVLD, byteStripingIN, flush, activeLanes, outRDY,
      input  inRDY, stripedLanes, laneMask, byteStripingVLD, counter
   );

   modport slave (
      input  ENB, laneVLD, byteStripingIN, flush, activeLanes, outRDY,
      output inRDY, stripedLanes, laneMask, byteStripingVLD, counter
   );
endinterface

// File: rtl/byte_striping_lanes.sv
// Round-robin byte striper: fills 1..LANES lanes, one byte per accepted cycle, and emits
// each stripe (or flushed PAD-filled partial stripe) through a valid/ready output register.
module byte_striping_lanes #(
   parameter int               WIDTH = 8,
   parameter int               LANES = 4,
   parameter logic [WIDTH-1:0] PAD   = '0
) (
   input logic                  clk1Mhz,
   input logic                  reset,
   byte_striping_lanes_if.slave bus
);
   localparam int CW = $clog2(LANES);
   localparam int AW = CW + 1;

   typedef logic [LANES-1:0][WIDTH-1:0] lanes_t;

   logic [CW-1:0] counter_q, counter_d;
   logic [AW-1:0] n_q, n_d;
   lanes_t        asm_q, asm_d;
   logic [LANES-1:0] fill_q, fill_d;
   lanes_t        stripe_q, stripe_d;
   logic [LANES-1:0] mask_q, mask_d;
   logic          vld_q, vld_d;

   logic [AW-1:0] n_live, n_eff;
   lanes_t        asm_next;
   logic [LANES-1:0] fill_next;
   logic          in_rdy, accept, at_last, close;

   // Powers of two up to LANES are honoured; anything else falls back to all lanes.
   function automatic logic [AW-1:0] decode_lanes(input logic [AW-1:0] a);
      if (a != '0 && (a & (a - AW'(1))) == '0 && a <= AW'(LANES))
         return a;
      return AW'(LANES);
   endfunction

   always_comb begin
      n_live  = decode_lanes(bus.activeLanes);
      // The first byte of a stripe must use the live lane count, before it is latched.
      n_eff   = (counter_q == '0) ? n_live : n_q;
      in_rdy  = !vld_q || bus.outRDY;
      accept  = bus.laneVLD && bus.ENB && in_rdy;
      for (int i = 0; i < LANES; i++) begin
         asm_next[i]  = (accept && counter_q == CW'(i)) ? bus.byteStripingIN : asm_q[i];
         fill_next[i] = fill_q[i] || (accept && counter_q == CW'(i));
      end
      at_last = ({1'b0, counter_q} == (n_eff - AW'(1)));
      close   = (accept && at_last) ||
                (bus.flush && bus.ENB && in_rdy && (counter_q != '0 || accept));

      counter_d = counter_q;
      n_d       = n_q;
      asm_d     = asm_q;
      fill_d    = fill_q;
      stripe_d  = stripe_q;
      mask_d    = mask_q;
      vld_d     = vld_q;

      if (accept && counter_q == '0)
         n_d = n_live;

      if (close) begin
         // Unfilled lanes still hold PAD from the last clear, so the buffer goes out as is.
         stripe_d  = asm_next;
         mask_d    = fill_next;
         vld_d     = 1'b1;
         counter_d = '0;
         asm_d     = {LANES{PAD}};
         fill_d    = '0;
      end else begin
         if (accept) begin
            asm_d     = asm_next;
            fill_d    = fill_next;
            counter_d = counter_q + CW'(1);
         end
         if (vld_q && bus.outRDY)
            vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk1Mhz or negedge reset) begin
      if (!reset) begin
         counter_q <= '0;
         n_q       <= AW'(LANES);
         asm_q     <= {LANES{PAD}};
         fill_q    <= '0;
         stripe_q  <= '0;
         mask_q    <= '0;
         vld_q     <= 1'b0;
      end else begin
         counter_q <= counter_d;
         n_q       <= n_d;
         asm_q     <= asm_d;
         fill_q    <= fill_d;
         stripe_q  <= stripe_d;
         mask_q    <= mask_d;
         vld_q     <= vld_d;
      end
   end

   assign bus.inRDY           = in_rdy;
   assign bus.stripedLanes    = stripe_q;
   assign bus.laneMask        = mask_q;
   assign bus.byteStripingVLD = vld_q;
   assign bus.counter         = counter_q;
endmodule

// File: tb/tb_byte_striping_lanes.sv
// Directed bench for byte_striping_lanes (LANES=4, WIDTH=8, PAD=00) with hand-computed stripes.
module tb_byte_striping_lanes;
   logic clk1Mhz;
   logic reset;
   int   n_checks;
   int   n_fails;

   byte_striping_lanes_if #(.WIDTH(8), .LANES(4)) bus ();

   byte_striping_lanes #(.WIDTH(8), .LANES(4), .PAD(8'h00)) dut (
      .clk1Mhz (clk1Mhz),
      .reset   (reset),
      .bus     (bus)
   );

   initial clk1Mhz = 1'b0;
   always #5 clk1Mhz = ~clk1Mhz;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk1Mhz);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.byteStripingIN = b;
      bus.laneVLD        = 1'b1;
      tick();
      bus.laneVLD        = 1'b0;
   endtask

   task automatic check_stripe(input string tag, input logic [31:0] lanes, input logic [3:0] mask);
      check_eq({tag, "_vld"},   32'(bus.byteStripingVLD), 32'd1);
      check_eq({tag, "_lanes"}, bus.stripedLanes, lanes);
      check_eq({tag, "_mask"},  32'(bus.laneMask), 32'(mask));
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      #2;
      check_eq("rst_vld",   32'(bus.byteStripingVLD), 32'd0);
      check_eq("rst_lanes", bus.stripedLanes, 32'd0);
      check_eq("rst_mask",  32'(bus.laneMask), 32'd0);
      check_eq("rst_cnt",   32'(bus.counter), 32'd0);
      #2;
      reset = 1'b1;
   endtask

   initial begin
      logic [7:0] t1 [4];
      n_checks = 0;
      n_fails  = 0;
      t1[0] = 8'h11; t1[1] = 8'h22; t1[2] = 8'h33; t1[3] = 8'h44;

      reset              = 1'b0;
      bus.ENB            = 1'b1;
      bus.laneVLD        = 1'b0;
      bus.byteStripingIN = '0;
      bus.flush          = 1'b0;
      bus.activeLanes    = 3'd4;
      bus.outRDY         = 1'b1;
      #3;
      check_eq("reset_vld",   32'(bus.byteStripingVLD), 32'd0);
      check_eq("reset_lanes", bus.stripedLanes, 32'd0);
      check_eq("reset_mask",  32'(bus.laneMask), 32'd0);
      check_eq("reset_cnt",   32'(bus.counter), 32'd0);
      check_eq("reset_inrdy", 32'(bus.inRDY), 32'd1);
      #5;
      reset = 1'b1;
      tick();

      // Full 4-lane stripe.
      for (int i = 0; i < 4; i++) begin
         check_eq("t1_cnt", 32'(bus.counter), 32'(i));
         send(t1[i]);
      end
      check_stripe("t1", 32'h44332211, 4'hF);
      check_eq("t1_cnt_wrap", 32'(bus.counter), 32'd0);
      tick();
      check_eq("t1_drain", 32'(bus.byteStripingVLD), 32'd0);

      // Backpressure: stripe held, 5th byte stalls until outRDY.
      bus.outRDY = 1'b0;
      send(8'h51); send(8'h52); send(8'h53); send(8'h54);
      check_stripe("t2_s1", 32'h54535251, 4'hF);
      check_eq("t2_inrdy", 32'(bus.inRDY), 32'd0);
      bus.byteStripingIN = 8'h55;
      bus.laneVLD        = 1'b1;
      tick(); tick(); tick();
      check_stripe("t2_hold", 32'h54535251, 4'hF);
      check_eq("t2_hold_cnt", 32'(bus.counter), 32'd0);
      bus.outRDY = 1'b1;
      tick();
      bus.laneVLD = 1'b0;
      check_eq("t2_take", 32'(bus.byteStripingVLD), 32'd0);
      check_eq("t2_cnt1", 32'(bus.counter), 32'd1);
      send(8'h56); send(8'h57); send(8'h58);
      check_stripe("t2_s2", 32'h58575655, 4'hF);
      tick();

      // Flush without and with a same-cycle byte; idle flush does nothing.
      send(8'hA1); send(8'hA2);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check_stripe("t3_flush", 32'h0000A2A1, 4'h3);
      check_eq("t3_cnt", 32'(bus.counter), 32'd0);
      send(8'hA1); send(8'hA2);
      bus.flush = 1'b1;
      send(8'hA3);
      bus.flush = 1'b0;
      check_stripe("t3_flush_b", 32'h00A3A2A1, 4'h7);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check_eq("t3_idle_flush", 32'(bus.byteStripingVLD), 32'd0);

      // Two-lane mode and a mid-stripe lane-count change.
      bus.activeLanes = 3'd2;
      send(8'h01); send(8'h02);
      check_stripe("t4_a", 32'h00000201, 4'h3);
      send(8'h03); send(8'h04);
      check_stripe("t4_b", 32'h00000403, 4'h3);
      send(8'h01);
      bus.activeLanes = 3'd4;
      send(8'h02);
      check_stripe("t4_latched", 32'h00000201, 4'h3);
      send(8'h03); send(8'h04);
      check_eq("t4_cnt", 32'(bus.counter), 32'd2);
      send(8'h05); send(8'h06);
      check_stripe("t4_c", 32'h06050403, 4'hF);

      // One lane, then an illegal count that falls back to four lanes.
      bus.activeLanes = 3'd1;
      send(8'h77);
      check_stripe("t4_n1", 32'h00000077, 4'h1);
      check_eq("t4_n1_cnt", 32'(bus.counter), 32'd0);
      bus.activeLanes = 3'd3;
      send(8'h31); send(8'h32); send(8'h33);
      check_eq("t4_n3_cnt", 32'(bus.counter), 32'd3);
      send(8'h34);
      check_stripe("t4_n3", 32'h34333231, 4'hF);
      bus.activeLanes = 3'd4;

      // ENB freeze mid-stripe, then drain with ENB low.
      send(8'hC1); send(8'hC2);
      bus.ENB            = 1'b0;
      bus.byteStripingIN = 8'hC3;
      bus.laneVLD        = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("t5_frozen", 32'(bus.counter), 32'd2);
      end
      bus.laneVLD = 1'b0;
      bus.ENB     = 1'b1;
      send(8'hC3); send(8'hC4);
      check_stripe("t5_resume", 32'hC4C3C2C1, 4'hF);
      bus.ENB = 1'b0;
      check_eq("t5_inrdy", 32'(bus.inRDY), 32'd1);
      tick();
      check_eq("t5_drain", 32'(bus.byteStripingVLD), 32'd0);
      bus.ENB = 1'b1;

      // Reset with a pending stripe, then mid-stripe, then a clean stripe.
      bus.outRDY = 1'b0;
      send(8'hE1); send(8'hE2); send(8'hE3); send(8'hE4);
      check_eq("t6_pend", 32'(bus.byteStripingVLD), 32'd1);
      pulse_reset();
      bus.outRDY = 1'b1;
      tick();
      send(8'hB1); send(8'hB2);
      check_eq("t6_partial", 32'(bus.counter), 32'd2);
      pulse_reset();
      tick();
      send(8'hD1); send(8'hD2); send(8'hD3); send(8'hD4);
      check_stripe("t6_clean", 32'hD4D3D2D1, 4'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
